// File: rtl/compute_unit_pkg.sv
// compute_unit_pkg: definitions shared by the compute unit front end.
//   - instruction width and field positions of the 16-bit instruction word
//   - control opcodes consumed by the warp scheduler (HALT, BAR, BRA)
//   - scheduler state encoding
package compute_unit_pkg;

  localparam int INST_WIDTH    = 16;
  localparam int OPCODE_MSB    = 15;
  localparam int OPCODE_LSB    = 12;
  localparam int IMM_LONG_MSB  = 7;
  localparam int IMM_LONG_LSB  = 0;
  localparam int IMM_SHORT_MSB = 3;
  localparam int IMM_SHORT_LSB = 0;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_BAR  = 4'hE;
  localparam logic [3:0] OP_BRA  = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SELECT     = 3'd1,
    ST_FETCH_REQ  = 3'd2,
    ST_FETCH_WAIT = 3'd3,
    ST_EXEC       = 3'd4,
    ST_ISSUE      = 3'd5,
    ST_DONE       = 3'd6
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   [N-1:0]  request vector
//   last  [W-1:0]  index granted last time; search starts at last+1
//   grant [N-1:0]  one-hot grant (all zero when nothing requests)
//   valid          at least one request present
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic         valid
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: per-warp PC sequencer with round-robin issue.
// Picks an eligible warp, fetches its instruction, consumes HALT/BAR/BRA
// locally and forwards everything else to the decoder tagged with warp/pc.
//
// Ports:
//   clk, rst (sync, active high)
//   start, warp_enable[NUM_WARPS]          launch (IDLE/DONE only)
//   fetch_req_valid/ready, fetch_pc        instruction fetch request
//   fetch_rsp_valid, fetch_instruction     instruction return
//   issue_valid/ready, issue_instruction,
//   issue_warp_id, issue_pc                decoder issue port
//   done                                   all enabled warps halted
//   perf_issued, perf_stall (32b)          only with WARP_ISSUE_PERF_EN
//
// state         | meaning
// --------------+---------------------------------------------------
// ST_IDLE       | after reset, waiting for start
// ST_SELECT     | round-robin choice among eligible warps
// ST_FETCH_REQ  | fetch request presented for cur_warp
// ST_FETCH_WAIT | waiting for the instruction to return
// ST_EXEC       | decode opcode, consume control instructions
// ST_ISSUE      | instruction offered to the decoder
// ST_DONE       | every enabled warp halted, done=1
module warp_issue_scheduler
  import compute_unit_pkg::*;
#(
  parameter int NUM_WARPS  = 4,
  parameter int INST_WIDTH = 16,
  parameter int PC_WIDTH   = 8,
  localparam int WID = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_WARPS-1:0]  warp_enable,
  output logic                  fetch_req_valid,
  input  logic                  fetch_req_ready,
  output logic [PC_WIDTH-1:0]   fetch_pc,
  input  logic                  fetch_rsp_valid,
  input  logic [INST_WIDTH-1:0] fetch_instruction,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [INST_WIDTH-1:0] issue_instruction,
  output logic [WID-1:0]        issue_warp_id,
  output logic [PC_WIDTH-1:0]   issue_pc,
  output logic                  done
`ifdef WARP_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  sched_state_e          state;
  logic [PC_WIDTH-1:0]   pc_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]  active_q, halted_q, waiting_q;
  logic [NUM_WARPS-1:0]  halted_nxt, waiting_nxt, live_nxt;
  logic [NUM_WARPS-1:0]  eligible, grant;
  logic                  sel_valid;
  logic [WID-1:0]        sel_warp, last_warp, cur_warp;
  logic [INST_WIDTH-1:0] inst_q;
  logic [3:0]            opcode;

  assign eligible = active_q & ~halted_q & ~waiting_q;
  assign opcode   = inst_q[OPCODE_MSB:OPCODE_LSB];

  rr_arbiter #(.N(NUM_WARPS)) u_rr_arbiter (
    .req   (eligible),
    .last  (last_warp),
    .grant (grant),
    .valid (sel_valid)
  );

  always_comb begin
    sel_warp = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (grant[i]) sel_warp = WID'(i);
    end
  end

  // Barrier release sees this cycle's HALT/BAR, so the last warp arriving
  // (or halting) frees the others in the same cycle.
  always_comb begin
    halted_nxt  = halted_q;
    waiting_nxt = waiting_q;
    if (state == ST_EXEC && opcode == OP_HALT) halted_nxt[cur_warp] = 1'b1;
    if (state == ST_EXEC && opcode == OP_BAR)  waiting_nxt[cur_warp] = 1'b1;
    live_nxt = active_q & ~halted_nxt;
    if (live_nxt != '0 && waiting_nxt == live_nxt) waiting_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      active_q  <= '0;
      halted_q  <= '0;
      waiting_q <= '0;
      last_warp <= WID'(NUM_WARPS - 1);
      cur_warp  <= '0;
      inst_q    <= '0;
      for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
    end else begin
      halted_q  <= halted_nxt;
      waiting_q <= waiting_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (warp_enable != '0) begin
              for (int i = 0; i < NUM_WARPS; i++) pc_q[i] <= '0;
              active_q  <= warp_enable;
              halted_q  <= '0;
              waiting_q <= '0;
              state     <= ST_SELECT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SELECT: begin
          if (sel_valid) begin
            cur_warp  <= sel_warp;
            last_warp <= sel_warp;
            state     <= ST_FETCH_REQ;
          end else if ((active_q & ~halted_q) == '0) begin
            state <= ST_DONE;
          end
        end
        ST_FETCH_REQ: begin
          if (fetch_req_ready) state <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (fetch_rsp_valid) begin
            inst_q <= fetch_instruction;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_HALT: state <= ST_SELECT;
            OP_BAR: begin
              pc_q[cur_warp] <= pc_q[cur_warp] + PC_WIDTH'(1);
              state          <= ST_SELECT;
            end
            OP_BRA: begin
              pc_q[cur_warp] <= PC_WIDTH'(inst_q[IMM_LONG_MSB:IMM_LONG_LSB]);
              state          <= ST_SELECT;
            end
            default: state <= ST_ISSUE;
          endcase
        end
        ST_ISSUE: begin
          if (issue_ready) begin
            pc_q[cur_warp] <= pc_q[cur_warp] + PC_WIDTH'(1);
            state          <= ST_SELECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data outputs are gated to zero outside their valid states.
  assign fetch_req_valid   = (state == ST_FETCH_REQ);
  assign fetch_pc          = fetch_req_valid ? pc_q[cur_warp] : '0;
  assign issue_valid       = (state == ST_ISSUE);
  assign issue_instruction = issue_valid ? inst_q : '0;
  assign issue_warp_id     = issue_valid ? cur_warp : '0;
  assign issue_pc          = issue_valid ? pc_q[cur_warp] : '0;
  assign done              = (state == ST_DONE);

`ifdef WARP_ISSUE_PERF_EN
  logic start_ok;
  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue_valid && issue_ready && perf_issued != '1)
        perf_issued <= perf_issued + 32'd1;
      if (issue_valid && !issue_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
